// File: rtl/cpu_bus_bridge.sv
// Bridges 68000-style AS/UDS/LDS bus cycles onto a request/ack memory port,
// returning DTACK with registered read data, VPA for IACK, and a cycle timeout.
module cpu_bus_bridge #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_cpu_as,
  input  logic                  io_cpu_rw,
  input  logic                  io_cpu_uds,
  input  logic                  io_cpu_lds,
  input  logic [2:0]            io_cpu_fc,
  input  logic [ADDR_WIDTH-1:0] io_cpu_addr,
  input  logic [DATA_WIDTH-1:0] io_cpu_dout,
  output logic [DATA_WIDTH-1:0] io_cpu_din,
  output logic                  io_cpu_dtack,
  output logic                  io_cpu_vpa,
  output logic                  io_mem_rd,
  output logic                  io_mem_wr,
  output logic [ADDR_WIDTH-1:0] io_mem_addr,
  output logic [1:0]            io_mem_mask,
  output logic [DATA_WIDTH-1:0] io_mem_din,
  input  logic                  io_mem_ack,
  input  logic                  io_mem_valid,
  input  logic [DATA_WIDTH-1:0] io_mem_dout,
  output logic                  io_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    IACK
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [15:0]           count_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            mask_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  timeout_q;

  logic start;
  logic capture;
  logic expire;
  logic at_limit;

  // ">=" rather than "==" so a read acked on its last REQ cycle can still
  // time out in WAIT instead of waiting for the counter to wrap.
  assign at_limit = (count_q >= LIMIT);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_cpu_as && (io_cpu_uds || io_cpu_lds)) begin
          if (io_cpu_fc == 3'b111) begin
            state_d = IACK;
          end else begin
            state_d = REQ;
            start   = 1'b1;
          end
        end
      end
      REQ: begin
        if (io_mem_ack) begin
          if (!rw_q) begin
            state_d = DONE;
          end else if (io_mem_valid) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (at_limit) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        if (io_mem_valid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (at_limit) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!io_cpu_as) state_d = IDLE;
      end
      IACK: begin
        if (!io_cpu_as) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= expire;
      if (start) begin
        count_q <= '0;
        rw_q    <= io_cpu_rw;
        addr_q  <= io_cpu_addr;
        mask_q  <= {io_cpu_uds, io_cpu_lds};
        wdata_q <= io_cpu_dout;
      end else if (state_q == REQ || state_q == WAIT) begin
        count_q <= count_q + 16'd1;
      end
      // Forced termination of a read returns all ones; writes leave din alone.
      if (capture) begin
        rdata_q <= io_mem_dout;
      end else if (expire && rw_q) begin
        rdata_q <= '1;
      end
    end
  end

  assign io_mem_rd    = (state_q == REQ) && rw_q;
  assign io_mem_wr    = (state_q == REQ) && !rw_q;
  assign io_mem_addr  = addr_q;
  assign io_mem_mask  = mask_q;
  assign io_mem_din   = wdata_q;
  assign io_cpu_din   = rdata_q;
  assign io_cpu_dtack = (state_q == DONE);
  assign io_cpu_vpa   = (state_q == IACK);
  assign io_timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed vector bench for cpu_bus_bridge: table of per-cycle vectors plus
// hand-written timeout sequences, run with TIMEOUT=8.
module tb_cpu_bus_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_cpu_as, io_cpu_rw, io_cpu_uds, io_cpu_lds;
  logic [2:0]  io_cpu_fc;
  logic [22:0] io_cpu_addr;
  logic [15:0] io_cpu_dout;
  logic [15:0] io_cpu_din;
  logic        io_cpu_dtack, io_cpu_vpa;
  logic        io_mem_rd, io_mem_wr;
  logic [22:0] io_mem_addr;
  logic [1:0]  io_mem_mask;
  logic [15:0] io_mem_din;
  logic        io_mem_ack, io_mem_valid;
  logic [15:0] io_mem_dout;
  logic        io_timeout;

  int n_checks = 0;
  int miscompares = 0;

  cpu_bus_bridge #(.ADDR_WIDTH(23), .DATA_WIDTH(16), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .io_cpu_as(io_cpu_as), .io_cpu_rw(io_cpu_rw),
    .io_cpu_uds(io_cpu_uds), .io_cpu_lds(io_cpu_lds),
    .io_cpu_fc(io_cpu_fc), .io_cpu_addr(io_cpu_addr),
    .io_cpu_dout(io_cpu_dout), .io_cpu_din(io_cpu_din),
    .io_cpu_dtack(io_cpu_dtack), .io_cpu_vpa(io_cpu_vpa),
    .io_mem_rd(io_mem_rd), .io_mem_wr(io_mem_wr),
    .io_mem_addr(io_mem_addr), .io_mem_mask(io_mem_mask),
    .io_mem_din(io_mem_din), .io_mem_ack(io_mem_ack),
    .io_mem_valid(io_mem_valid), .io_mem_dout(io_mem_dout),
    .io_timeout(io_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, as, rw, uds, lds;
    logic [2:0]  fc;
    logic [22:0] addr;
    logic [15:0] dout;
    logic        ack, valid;
    logic [15:0] mdout;
    logic [15:0] e_din;
    logic        e_dtack, e_vpa, e_rd, e_wr;
    logic [22:0] e_addr;
    logic [1:0]  e_mask;
    logic [15:0] e_mdin;
    logic        e_to;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    io_cpu_as    = v.as;
    io_cpu_rw    = v.rw;
    io_cpu_uds   = v.uds;
    io_cpu_lds   = v.lds;
    io_cpu_fc    = v.fc;
    io_cpu_addr  = v.addr;
    io_cpu_dout  = v.dout;
    io_mem_ack   = v.ack;
    io_mem_valid = v.valid;
    io_mem_dout  = v.mdout;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d din", i),   32'(io_cpu_din),   32'(v.e_din));
    checkOutput($sformatf("v%0d dtack", i), 32'(io_cpu_dtack), 32'(v.e_dtack));
    checkOutput($sformatf("v%0d vpa", i),   32'(io_cpu_vpa),   32'(v.e_vpa));
    checkOutput($sformatf("v%0d rd", i),    32'(io_mem_rd),    32'(v.e_rd));
    checkOutput($sformatf("v%0d wr", i),    32'(io_mem_wr),    32'(v.e_wr));
    checkOutput($sformatf("v%0d addr", i),  32'(io_mem_addr),  32'(v.e_addr));
    checkOutput($sformatf("v%0d mask", i),  32'(io_mem_mask),  32'(v.e_mask));
    checkOutput($sformatf("v%0d mdin", i),  32'(io_mem_din),   32'(v.e_mdin));
    checkOutput($sformatf("v%0d tmo", i),   32'(io_timeout),   32'(v.e_to));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd_cycles;
    int to_pulses;

    // rst as rw u l fc addr dout ack val mdout | din dtack vpa rd wr maddr mask mdin to
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,23'h000000,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,1'b0,23'h000000,2'd0,16'h0000,1'b0};
    // read 0x100000: two REQ cycles, ack, two WAIT cycles, valid BEEF
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b1,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b1,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b0,1'b1,16'hBEEF, 16'hBEEF,1'b1,1'b0,1'b0,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h100000,16'h0000,1'b0,1'b0,16'h0000, 16'hBEEF,1'b1,1'b0,1'b0,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'd5,23'h100000,16'h0000,1'b0,1'b0,16'h0000, 16'hBEEF,1'b0,1'b0,1'b0,1'b0,23'h100000,2'd3,16'h0000,1'b0};
    // write LDS only 0x00A5; dout changes while waiting, valid during write ack ignored
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'd5,23'h000200,16'h00A5,1'b0,1'b0,16'h0000, 16'hBEEF,1'b0,1'b0,1'b0,1'b1,23'h000200,2'd1,16'h00A5,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'd5,23'h000200,16'h5A5A,1'b0,1'b0,16'h0000, 16'hBEEF,1'b0,1'b0,1'b0,1'b1,23'h000200,2'd1,16'h00A5,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'd5,23'h000200,16'h5A5A,1'b1,1'b1,16'h1111, 16'hBEEF,1'b1,1'b0,1'b0,1'b0,23'h000200,2'd1,16'h00A5,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd5,23'h000200,16'h5A5A,1'b0,1'b0,16'h0000, 16'hBEEF,1'b0,1'b0,1'b0,1'b0,23'h000200,2'd1,16'h00A5,1'b0};
    // read UDS only with ack+valid together: WAIT skipped
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0,3'd5,23'h000300,16'h0000,1'b0,1'b0,16'h0000, 16'hBEEF,1'b0,1'b0,1'b1,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b1,1'b0,3'd5,23'h000300,16'h0000,1'b1,1'b1,16'h1234, 16'h1234,1'b1,1'b0,1'b0,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'd5,23'h000300,16'h0000,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b0,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    // interrupt acknowledge: VPA, no request, latches untouched
    vecs[16] = '{1'b0,1'b1,1'b1,1'b0,1'b1,3'd7,23'h7FFFFF,16'h0000,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b1,1'b0,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    vecs[17] = '{1'b0,1'b1,1'b1,1'b0,1'b1,3'd7,23'h7FFFFF,16'h0000,1'b1,1'b0,16'h0000, 16'h1234,1'b0,1'b1,1'b0,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    vecs[18] = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'd7,23'h7FFFFF,16'h0000,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b0,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    // AS without strobes waits; then write whose AS drops before ack
    vecs[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,3'd5,23'h000400,16'h0042,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b0,1'b0,23'h000300,2'd2,16'h0000,1'b0};
    vecs[20] = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'd5,23'h000400,16'h0042,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b0,1'b1,23'h000400,2'd1,16'h0042,1'b0};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd5,23'h000400,16'h0042,1'b1,1'b0,16'h0000, 16'h1234,1'b1,1'b0,1'b0,1'b0,23'h000400,2'd1,16'h0042,1'b0};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd5,23'h000400,16'h0042,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b0,1'b0,23'h000400,2'd1,16'h0042,1'b0};
    // reset in WAIT, stale valid in IDLE, then a clean read
    vecs[23] = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h000500,16'h0000,1'b0,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b1,1'b0,23'h000500,2'd3,16'h0000,1'b0};
    vecs[24] = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h000500,16'h0000,1'b1,1'b0,16'h0000, 16'h1234,1'b0,1'b0,1'b0,1'b0,23'h000500,2'd3,16'h0000,1'b0};
    vecs[25] = '{1'b1,1'b1,1'b1,1'b1,1'b1,3'd5,23'h000500,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,1'b0,23'h000000,2'd0,16'h0000,1'b0};
    vecs[26] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd5,23'h000000,16'h0000,1'b0,1'b1,16'hDEAD, 16'h0000,1'b0,1'b0,1'b0,1'b0,23'h000000,2'd0,16'h0000,1'b0};
    vecs[27] = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h000600,16'h0000,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b1,1'b0,23'h000600,2'd3,16'h0000,1'b0};
    vecs[28] = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd5,23'h000600,16'h0000,1'b1,1'b1,16'h7777, 16'h7777,1'b1,1'b0,1'b0,1'b0,23'h000600,2'd3,16'h0000,1'b0};
    vecs[29] = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'd5,23'h000600,16'h0000,1'b0,1'b0,16'h0000, 16'h7777,1'b0,1'b0,1'b0,1'b0,23'h000600,2'd3,16'h0000,1'b0};

    $display("[TB] applying %0d table vectors", NVEC);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Ack+valid on the eighth REQ cycle beats the timeout.
    io_cpu_as = 1'b1; io_cpu_rw = 1'b1; io_cpu_uds = 1'b1; io_cpu_lds = 1'b1;
    io_cpu_fc = 3'd5; io_cpu_addr = 23'h000700;
    io_mem_ack = 1'b0; io_mem_valid = 1'b0; io_mem_dout = 16'h0000;
    tick();
    checkOutput("edge start rd", 32'(io_mem_rd), 32'd1);
    repeat (7) tick();
    checkOutput("edge last rd", 32'(io_mem_rd), 32'd1);
    checkOutput("edge last dtack", 32'(io_cpu_dtack), 32'd0);
    io_mem_ack = 1'b1; io_mem_valid = 1'b1; io_mem_dout = 16'h4321;
    tick();
    checkOutput("edge dtack", 32'(io_cpu_dtack), 32'd1);
    checkOutput("edge tmo", 32'(io_timeout), 32'd0);
    checkOutput("edge din", 32'(io_cpu_din), 32'h4321);
    io_mem_ack = 1'b0; io_mem_valid = 1'b0; io_cpu_as = 1'b0;
    io_cpu_uds = 1'b0; io_cpu_lds = 1'b0;
    tick();
    checkOutput("edge idle dtack", 32'(io_cpu_dtack), 32'd0);

    // Read never acked: rd for 8 cycles, then forced DONE with all-ones data.
    io_cpu_as = 1'b1; io_cpu_uds = 1'b1; io_cpu_lds = 1'b1; io_cpu_addr = 23'h000710;
    rd_cycles = 0;
    to_pulses = 0;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (io_mem_rd) rd_cycles++;
      if (io_timeout) to_pulses++;
      if (io_cpu_dtack) break;
      tick();
    end
    checkOutput("tmo rd cycles", 32'(rd_cycles), 32'd8);
    checkOutput("tmo dtack", 32'(io_cpu_dtack), 32'd1);
    checkOutput("tmo pulse", 32'(io_timeout), 32'd1);
    checkOutput("tmo din", 32'(io_cpu_din), 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (io_timeout) to_pulses++;
    end
    checkOutput("tmo pulse count", 32'(to_pulses), 32'd1);
    checkOutput("tmo dtack hold", 32'(io_cpu_dtack), 32'd1);
    io_cpu_as = 1'b0; io_cpu_uds = 1'b0; io_cpu_lds = 1'b0;
    tick();
    checkOutput("tmo idle dtack", 32'(io_cpu_dtack), 32'd0);
    checkOutput("tmo idle din", 32'(io_cpu_din), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, miscompares);
    $finish;
  end

endmodule
